// File: rtl/mux_serializer_8_pkg.sv
// Shared types and constants for the 8-bit serializer that feeds the 8-to-1 mux.
package mux_serializer_8_pkg;

    localparam int unsigned MuxWidth = 8;
    localparam int unsigned SelW     = 3;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    function automatic logic [SelW-1:0] sel_first(input bit lsb_first);
        return lsb_first ? 3'd0 : 3'd7;
    endfunction

    function automatic logic [SelW-1:0] sel_last(input bit lsb_first);
        return lsb_first ? 3'd7 : 3'd0;
    endfunction

endpackage

// File: rtl/mux_serializer_8_mux.sv
// Plain 8-to-1 multiplexer: y = d[s].
module Mux_8to1 (
    input  logic [2:0] s,
    input  logic [7:0] d,
    output logic       y
);

    assign y = d[s];

endmodule

// File: rtl/mux_serializer_8.sv
// Parallel-to-serial stage: holds a word and steps the mux select through it, one bit per enable.
module mux_serializer_8
    import mux_serializer_8_pkg::*;
#(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    input  logic              shift_en_i,
    output logic [DATA_W-1:0] mux_d_o,
    output logic [SelW-1:0]   mux_s_o,
    output logic              ser_out_o,
    output logic              ser_valid_o,
    output logic              frame_start_o,
    output logic              frame_done_o
);

    localparam logic [SelW-1:0] SelFirst = sel_first(LSB_FIRST);
    localparam logic [SelW-1:0] SelLast  = sel_last(LSB_FIRST);

    if (DATA_W != MuxWidth) begin : g_width_check
        $error("mux_serializer_8: DATA_W must be 8 to match the 8-to-1 mux");
    end

    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [SelW-1:0]   sel_q;
    logic              last_bit;
    logic              accept;

    always_comb begin
        last_bit     = (state_q == StShift) && (sel_q == SelLast) && shift_en_i;
        // Ready in the last-bit cycle too, so a waiting word follows with no gap.
        load_ready_o = !reset_i && ((state_q == StIdle) || last_bit);
        accept       = load_valid_i && load_ready_o;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            sel_q   <= SelFirst;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_q  <= load_data_i;
                        sel_q   <= SelFirst;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (shift_en_i) begin
                        if (sel_q == SelLast) begin
                            sel_q <= SelFirst;
                            if (accept) begin
                                data_q <= load_data_i;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else if (LSB_FIRST) begin
                            sel_q <= sel_q + 3'd1;
                        end else begin
                            sel_q <= sel_q - 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ser_valid_o   = (state_q == StShift);
        // No wrap inside a frame, so the start index is only seen on the first bit.
        frame_start_o = (state_q == StShift) && (sel_q == SelFirst);
        frame_done_o  = last_bit;
    end

    assign mux_d_o = data_q;
    assign mux_s_o = sel_q;

    Mux_8to1 u_mux (
        .s (sel_q),
        .d (data_q[7:0]),
        .y (ser_out_o)
    );

endmodule

// File: tb/tb_mux_serializer_8.sv
// Directed bench for mux_serializer_8: LSB-first and MSB-first instances on shared stimulus.
module tb_mux_serializer_8;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       shift_en;

    logic       l_ready, l_ser, l_valid, l_start, l_done;
    logic [7:0] l_d;
    logic [2:0] l_s;
    logic       m_ready, m_ser, m_valid, m_start, m_done;
    logic [7:0] m_d;
    logic [2:0] m_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_serializer_8 #(.LSB_FIRST(1'b1), .DATA_W(8)) u_lsb (
        .clk_i         (clk),
        .reset_i       (reset),
        .load_valid_i  (load_valid),
        .load_data_i   (load_data),
        .load_ready_o  (l_ready),
        .shift_en_i    (shift_en),
        .mux_d_o       (l_d),
        .mux_s_o       (l_s),
        .ser_out_o     (l_ser),
        .ser_valid_o   (l_valid),
        .frame_start_o (l_start),
        .frame_done_o  (l_done)
    );

    mux_serializer_8 #(.LSB_FIRST(1'b0), .DATA_W(8)) u_msb (
        .clk_i         (clk),
        .reset_i       (reset),
        .load_valid_i  (load_valid),
        .load_data_i   (load_data),
        .load_ready_o  (m_ready),
        .shift_en_i    (shift_en),
        .mux_d_o       (m_d),
        .mux_s_o       (m_s),
        .ser_out_o     (m_ser),
        .ser_valid_o   (m_valid),
        .frame_start_o (m_start),
        .frame_done_o  (m_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle(input logic lv, input logic [7:0] ld, input logic se);
        @(negedge clk);
        load_valid = lv;
        load_data  = ld;
        shift_en   = se;
        #1;
    endtask

    // One LSB-first frame already loaded; optionally offer the next word on the last bit,
    // and optionally poke a stray word mid-frame at poke_idx.
    task automatic lsb_frame(input logic [7:0] word, input logic last_lv,
                             input logic [7:0] last_word, input int poke_idx);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) next_cycle(last_lv, last_word, 1'b1);
            else if (i == poke_idx) next_cycle(1'b1, 8'hFF, 1'b1);
            else next_cycle(1'b0, 8'h00, 1'b1);
            check("frm_valid", l_valid, 1'b1);
            check("frm_sel", l_s, i);
            check("frm_bit", l_ser, word[i]);
            check("frm_data", l_d, word);
            check("frm_start", l_start, i == 0);
            check("frm_done", l_done, i == 7);
            check("frm_ready", l_ready, i == 7);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lsb_seq;
        logic [7:0] msb_seq;
        int         len;
        int         dones;

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        shift_en   = 1'b0;
        #12;
        check("rst_ready", l_ready, 1'b0);
        check("rst_valid", l_valid, 1'b0);
        check("rst_d", l_d, 8'h00);
        check("rst_s_lsb", l_s, 3'd0);
        check("rst_s_msb", m_s, 3'd7);
        check("rst_start", l_start, 1'b0);
        check("rst_done", l_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_ready", l_ready, 1'b1);

        // Basic frame on both instances: 8'b10010101.
        lsb_seq = 8'b10010101;  // bit i = expected i-th serial bit
        msb_seq = 8'b10101001;
        next_cycle(1'b1, 8'h95, 1'b1);
        check("ld_ready_lsb", l_ready, 1'b1);
        check("ld_ready_msb", m_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            next_cycle(1'b0, 8'h00, 1'b1);
            check("b_lsb_bit", l_ser, lsb_seq[i]);
            check("b_lsb_sel", l_s, i);
            check("b_lsb_start", l_start, i == 0);
            check("b_lsb_done", l_done, i == 7);
            check("b_msb_bit", m_ser, msb_seq[i]);
            check("b_msb_sel", m_s, 7 - i);
            check("b_msb_start", m_start, i == 0);
            check("b_msb_done", m_done, i == 7);
        end
        next_cycle(1'b0, 8'h00, 1'b1);
        check("b_end_valid_lsb", l_valid, 1'b0);
        check("b_end_ready_lsb", l_ready, 1'b1);
        check("b_end_s_lsb", l_s, 3'd0);
        check("b_end_valid_msb", m_valid, 1'b0);
        check("b_end_s_msb", m_s, 3'd7);

        // Back-to-back frames with no gap.
        next_cycle(1'b1, 8'hA5, 1'b1);
        lsb_frame(8'hA5, 1'b1, 8'h3C, -1);
        lsb_frame(8'h3C, 1'b0, 8'h00, -1);
        next_cycle(1'b0, 8'h00, 1'b1);
        check("b2b_idle", l_valid, 1'b0);

        // Stall: shift_en low for three cycles while mux_s = 3.
        next_cycle(1'b1, 8'hF0, 1'b1);
        len   = 0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle(1'b0, 8'h00, (len >= 3 && len < 6) ? 1'b0 : 1'b1);
            if (!l_valid) break;
            if (l_done) dones++;
            if (len >= 3 && len <= 6) begin
                check("stall_sel", l_s, 3'd3);
                check("stall_bit", l_ser, 1'b0);
            end
            len++;
        end
        check("stall_len", len, 11);
        check("stall_dones", dones, 1);

        // Reset mid-frame at mux_s = 4.
        next_cycle(1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) next_cycle(1'b0, 8'h00, 1'b1);
        check("mr_sel_pre", l_s, 3'd4);
        #2;
        reset = 1'b1;
        #1;
        check("mr_valid", l_valid, 1'b0);
        check("mr_d", l_d, 8'h00);
        check("mr_done", l_done, 1'b0);
        check("mr_ready", l_ready, 1'b0);
        check("mr_sel", l_s, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_rel_ready", l_ready, 1'b1);
        check("mr_rel_valid", l_valid, 1'b0);
        check("mr_rel_done", l_done, 1'b0);
        next_cycle(1'b1, 8'h69, 1'b1);
        lsb_frame(8'h69, 1'b0, 8'h00, -1);

        // Busy handshake: a word offered at mux_s = 2 must be ignored.
        next_cycle(1'b1, 8'h96, 1'b1);
        lsb_frame(8'h96, 1'b0, 8'h00, 2);
        next_cycle(1'b0, 8'h00, 1'b1);
        check("busy_idle", l_valid, 1'b0);
        check("busy_d", l_d, 8'h96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
